// File: rtl/ttt_board_engine_if.sv
// Move handshake bundle for ttt_board_engine: request fields, ready, and the ack/result pair.
interface ttt_board_engine_if #(
    parameter int unsigned AW = 2
);
    logic          move_valid;
    logic          move_ready;
    logic [1:0]    move_player;
    logic [AW-1:0] move_row;
    logic [AW-1:0] move_col;
    logic          move_ack;
    logic [2:0]    move_err;

    // Move source (pin controller / bench)
    modport master (
        output move_valid, move_player, move_row, move_col,
        input  move_ready, move_ack, move_err
    );

    // Board engine
    modport slave (
        input  move_valid, move_player, move_row, move_col,
        output move_ready, move_ack, move_err
    );
endinterface

// File: rtl/ttt_board_engine.sv
// N x N board engine: validates moves, writes cells, and runs a sequential
// K-in-a-row scan centred on the placed cell. Optional single-level undo is
// enabled by defining TTT_UNDO_EN (adds the undo input port).
module ttt_board_engine #(
    parameter int unsigned N = 3,
    parameter int unsigned K = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  new_game,
`ifdef TTT_UNDO_EN
    input  logic                  undo,
`endif
    ttt_board_engine_if.slave     mv,
    input  logic [((N > 2) ? $clog2(N) : 1)-1:0] rd_row,
    input  logic [((N > 2) ? $clog2(N) : 1)-1:0] rd_col,
    output logic [1:0]            rd_cell,
    output logic [1:0]            turn,
    output logic [1:0]            win,
    output logic                  draw
);
    localparam int unsigned AW   = (N > 2) ? $clog2(N) : 1;
    localparam int unsigned MW   = $clog2(N * N + 1);
    localparam int unsigned NP   = 1 << AW;
    localparam int unsigned OW   = $clog2(2 * K - 1);
    localparam int unsigned RW   = $clog2(K + 1);
    localparam int unsigned LAST = 2 * K - 2;

    typedef enum logic [1:0] {IDLE, CHECK, SCAN, DONE} state_t;

    state_t         state;
    logic           ready_q;
    logic [1:0]     board [NP][NP];
    logic [MW-1:0]  cnt;
    logic           ack_q;
    logic [2:0]     err_q;
    logic [1:0]     cap_player;
    logic [AW-1:0]  cap_row;
    logic [AW-1:0]  cap_col;
    logic [2:0]     chk_err;
    logic [1:0]     dir;
    logic [OW-1:0]  off;
    logic [RW-1:0]  run;
`ifdef TTT_UNDO_EN
    logic           last_valid;
    logic [AW-1:0]  last_row;
    logic [AW-1:0]  last_col;
    logic [1:0]     last_player;
`endif

    logic [2:0]     err_c;
    int             s_off;
    int             sr;
    int             sc;
    logic           on_board;
    logic           hit;
    logic [RW-1:0]  run_nxt;

    // Ready drops combinationally while a clear or undo owns the cycle
`ifdef TTT_UNDO_EN
    assign mv.move_ready = ready_q & ~new_game & ~undo;
`else
    assign mv.move_ready = ready_q & ~new_game;
`endif
    assign mv.move_ack = ack_q;
    assign mv.move_err = err_q;

    // Combinational read port for display cycling; out-of-range reads as empty
    assign rd_cell = (32'(rd_row) < N && 32'(rd_col) < N) ? board[rd_row][rd_col] : 2'b00;

    // Prioritised error evaluation of the captured move
    always_comb begin
        err_c = 3'd0;
        if (win != 2'b00 || draw) begin
            err_c = 3'd1;
        end else if (cap_player == 2'b00 || cap_player == 2'b11) begin
            err_c = 3'd2;
        end else if (32'(cap_row) >= N || 32'(cap_col) >= N) begin
            err_c = 3'd3;
        end else if (cap_player != turn) begin
            err_c = 3'd4;
        end else if (board[cap_row][cap_col] != 2'b00) begin
            err_c = 3'd5;
        end
    end

    // Current scan cell: direction 0 row, 1 column, 2 diagonal, 3 anti-diagonal
    always_comb begin
        s_off = int'(off) - (int'(K) - 1);
        sr    = int'(cap_row);
        sc    = int'(cap_col);
        case (dir)
            2'd0: sc = sc + s_off;
            2'd1: sr = sr + s_off;
            2'd2: begin
                sr = sr + s_off;
                sc = sc + s_off;
            end
            default: begin
                sr = sr + s_off;
                sc = sc - s_off;
            end
        endcase
        on_board = (sr >= 0) && (sr < int'(N)) && (sc >= 0) && (sc < int'(N));
        hit      = on_board && (board[AW'(sr)][AW'(sc)] == cap_player);
        run_nxt  = hit ? run + RW'(1) : '0;
    end

    // Move FSM, board storage and game status
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            ready_q    <= 1'b0;
            cnt        <= '0;
            turn       <= 2'b01;
            win        <= 2'b00;
            draw       <= 1'b0;
            ack_q      <= 1'b0;
            err_q      <= 3'd0;
            cap_player <= 2'b00;
            cap_row    <= '0;
            cap_col    <= '0;
            chk_err    <= 3'd0;
            dir        <= 2'd0;
            off        <= '0;
            run        <= '0;
            for (int i = 0; i < int'(NP); i++) begin
                for (int j = 0; j < int'(NP); j++) begin
                    board[i][j] <= 2'b00;
                end
            end
`ifdef TTT_UNDO_EN
            last_valid  <= 1'b0;
            last_row    <= '0;
            last_col    <= '0;
            last_player <= 2'b00;
`endif
        end else begin
            ack_q <= 1'b0;
            if (new_game) begin
                state   <= IDLE;
                ready_q <= 1'b1;
                cnt     <= '0;
                turn    <= 2'b01;
                win     <= 2'b00;
                draw    <= 1'b0;
                for (int i = 0; i < int'(NP); i++) begin
                    for (int j = 0; j < int'(NP); j++) begin
                        board[i][j] <= 2'b00;
                    end
                end
`ifdef TTT_UNDO_EN
                last_valid <= 1'b0;
`endif
            end else begin
                case (state)
                    IDLE: begin
                        ready_q <= 1'b1;
`ifdef TTT_UNDO_EN
                        if (undo) begin
                            if (last_valid && cnt != '0) begin
                                board[last_row][last_col] <= 2'b00;
                                cnt        <= cnt - MW'(1);
                                turn       <= last_player;
                                win        <= 2'b00;
                                draw       <= 1'b0;
                                last_valid <= 1'b0;
                            end
                        end else
`endif
                        if (mv.move_valid && ready_q) begin
                            cap_player <= mv.move_player;
                            cap_row    <= mv.move_row;
                            cap_col    <= mv.move_col;
                            ready_q    <= 1'b0;
                            state      <= CHECK;
                        end
                    end
                    CHECK: begin
                        chk_err <= err_c;
                        if (err_c != 3'd0) begin
                            state <= DONE;
                        end else begin
                            board[cap_row][cap_col] <= cap_player;
                            cnt   <= cnt + MW'(1);
                            dir   <= 2'd0;
                            off   <= '0;
                            run   <= '0;
                            state <= SCAN;
`ifdef TTT_UNDO_EN
                            last_valid  <= 1'b1;
                            last_row    <= cap_row;
                            last_col    <= cap_col;
                            last_player <= cap_player;
`endif
                        end
                    end
                    SCAN: begin
                        if (run_nxt == RW'(K)) begin
                            win   <= cap_player;
                            state <= DONE;
                        end else if (off == OW'(LAST)) begin
                            off <= '0;
                            run <= '0;
                            if (dir == 2'd3) begin
                                state <= DONE;
                            end else begin
                                dir <= dir + 2'd1;
                            end
                        end else begin
                            off <= off + OW'(1);
                            run <= run_nxt;
                        end
                    end
                    default: begin
                        ack_q   <= 1'b1;
                        err_q   <= chk_err;
                        ready_q <= 1'b1;
                        state   <= IDLE;
                        if (chk_err == 3'd0 && win == 2'b00) begin
                            turn <= (turn == 2'b01) ? 2'b10 : 2'b01;
                            if (cnt == MW'(N * N)) begin
                                draw <= 1'b1;
                            end
                        end
                    end
                endcase
            end
        end
    end
endmodule

// File: tb/tb_ttt_board_engine.sv
// Bench for ttt_board_engine: a 3x3/K=3 and a 5x5/K=4 instance driven by
// directed games, checked against a board-level game model.
module tb_ttt_board_engine;
    logic       clk;
    logic       reset;
    logic       new_game;
    logic       b_valid;
    logic [1:0] b_player;
    logic [2:0] b_row;
    logic [2:0] b_col;
    logic       b_undo;
    logic       sel;
    logic [5:0] rd_ptr;
    logic [1:0] cell3, cell5, turn3, turn5, win3, win5;
    logic       draw3, draw5;

    logic       cur_ready, cur_ack, cur_draw;
    logic [2:0] cur_err;
    logic [1:0] cur_turn, cur_win, cur_cell;

    int checks;
    int errors;
    bit chk_en;

    // Game model: [instance][row][col]
    logic [1:0] m_board [2][8][8];
    logic [1:0] m_turn [2];
    logic [1:0] m_win [2];
    bit         m_draw [2];
    int         m_cnt [2];
    bit         m_lv;
    int         m_lr, m_lc;
    logic [1:0] m_lp;

    ttt_board_engine_if #(.AW(2)) i3 ();
    ttt_board_engine_if #(.AW(3)) i5 ();

    assign i3.move_valid  = b_valid & ~sel;
    assign i3.move_player = b_player;
    assign i3.move_row    = b_row[1:0];
    assign i3.move_col    = b_col[1:0];
    assign i5.move_valid  = b_valid & sel;
    assign i5.move_player = b_player;
    assign i5.move_row    = b_row;
    assign i5.move_col    = b_col;

    ttt_board_engine #(.N(3), .K(3)) u3 (
        .clk(clk), .reset(reset), .new_game(new_game),
`ifdef TTT_UNDO_EN
        .undo(b_undo & ~sel),
`endif
        .mv(i3.slave), .rd_row(rd_ptr[4:3]), .rd_col(rd_ptr[1:0]),
        .rd_cell(cell3), .turn(turn3), .win(win3), .draw(draw3)
    );

    ttt_board_engine #(.N(5), .K(4)) u5 (
        .clk(clk), .reset(reset), .new_game(new_game),
`ifdef TTT_UNDO_EN
        .undo(b_undo & sel),
`endif
        .mv(i5.slave), .rd_row(rd_ptr[5:3]), .rd_col(rd_ptr[2:0]),
        .rd_cell(cell5), .turn(turn5), .win(win5), .draw(draw5)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Observe the instance under test
    always_comb begin
        if (sel) begin
            cur_ready = i5.move_ready; cur_ack = i5.move_ack; cur_err = i5.move_err;
            cur_turn = turn5; cur_win = win5; cur_draw = draw5; cur_cell = cell5;
        end else begin
            cur_ready = i3.move_ready; cur_ack = i3.move_ack; cur_err = i3.move_err;
            cur_turn = turn3; cur_win = win3; cur_draw = draw3; cur_cell = cell3;
        end
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int side(input bit s);
        return s ? 5 : 3;
    endfunction

    function automatic int klen(input bit s);
        return s ? 4 : 3;
    endfunction

    // The 3x3 read port sees only the low 2 bits of each coordinate
    function automatic int model_cell(input bit s, input int r, input int c);
        int n;
        int rr;
        int cc;
        n  = side(s);
        rr = s ? r : (r % 4);
        cc = s ? c : (c % 4);
        if (rr < n && cc < n) return int'(m_board[s][rr][cc]);
        return 0;
    endfunction

    task automatic model_clear();
        for (int s = 0; s < 2; s++) begin
            for (int r = 0; r < 8; r++)
                for (int c = 0; c < 8; c++)
                    m_board[s][r][c] = 2'b00;
            m_turn[s] = 2'b01;
            m_win[s]  = 2'b00;
            m_draw[s] = 1'b0;
            m_cnt[s]  = 0;
        end
        m_lv = 1'b0;
    endtask

    // Scan cycle on which a K-run through (r,c) is first found, 0 if none
    function automatic int win_step(input bit s, input int r, input int c, input logic [1:0] p);
        int n, k, dr, dc, run, rr, cc;
        n = side(s);
        k = klen(s);
        for (int d = 0; d < 4; d++) begin
            dr  = (d == 0) ? 0 : 1;
            dc  = (d == 1) ? 0 : ((d == 3) ? -1 : 1);
            run = 0;
            for (int o = 0; o < 2 * k - 1; o++) begin
                rr = r + dr * (o - (k - 1));
                cc = c + dc * (o - (k - 1));
                if (rr >= 0 && rr < n && cc >= 0 && cc < n && m_board[s][rr][cc] == p) run++;
                else run = 0;
                if (run == k) return d * (2 * k - 1) + o + 1;
            end
        end
        return 0;
    endfunction

    // Per-cycle status and read-port comparison against the model
    always @(negedge clk) begin
        if (chk_en) begin
            check("turn", int'(cur_turn), int'(m_turn[sel]));
            check("win", int'(cur_win), int'(m_win[sel]));
            check("draw", int'(cur_draw), int'(m_draw[sel]));
            check("rd_cell", int'(cur_cell), model_cell(sel, int'(rd_ptr[5:3]), int'(rd_ptr[2:0])));
            rd_ptr = rd_ptr + 6'd1;
        end
    end

    task automatic send(input logic [1:0] p, input int r, input int c);
        int w;
        w = 0;
        @(negedge clk);
        while (!cur_ready && w < 50) begin
            @(negedge clk);
            w++;
        end
        if (!cur_ready) check("ready_timeout", 0, 1);
        b_valid = 1'b1; b_player = p; b_row = 3'(r); b_col = 3'(c);
        @(posedge clk);
        #1;
        b_valid = 1'b0; b_player = ~p; b_row = ~3'(r); b_col = ~3'(c);
    endtask

    task automatic wait_ack(output int lat, output int err);
        lat = 0;
        do begin
            @(posedge clk);
            #1;
            lat++;
        end while (!cur_ack && lat < 300);
        err = int'(cur_err);
        if (!cur_ack) check("ack_timeout", 0, 1);
    endtask

    task automatic play(input bit s, input logic [1:0] p, input int r, input int c,
                        output int lat, output int err);
        int n, k, e, el, ws;
        chk_en = 1'b0;
        sel = s;
        n = side(s);
        k = klen(s);
        if (m_win[s] != 2'b00 || m_draw[s]) e = 1;
        else if (p == 2'b00 || p == 2'b11) e = 2;
        else if (r >= n || c >= n) e = 3;
        else if (p != m_turn[s]) e = 4;
        else if (m_board[s][r][c] != 2'b00) e = 5;
        else e = 0;
        el = 2;
        if (e == 0) begin
            m_board[s][r][c] = p;
            m_cnt[s]++;
            if (!s) begin
                m_lv = 1'b1; m_lr = r; m_lc = c; m_lp = p;
            end
            ws = win_step(s, r, c, p);
            if (ws != 0) begin
                el = ws + 2;
                m_win[s] = p;
            end else begin
                el = 4 * (2 * k - 1) + 2;
                m_turn[s] = (p == 2'b01) ? 2'b10 : 2'b01;
                if (m_cnt[s] == n * n) m_draw[s] = 1'b1;
            end
        end
        send(p, r, c);
        wait_ack(lat, err);
        check("latency", lat, el);
        check("move_err", err, e);
        chk_en = 1'b1;
        @(posedge clk);
        #1;
        check("ack_pulse", int'(cur_ack), 0);
    endtask

    task automatic do_new_game();
        @(negedge clk);
        new_game = 1'b1;
        @(posedge clk);
        #1;
        new_game = 1'b0;
        model_clear();
    endtask

`ifdef TTT_UNDO_EN
    task automatic do_undo();
        chk_en = 1'b0;
        sel = 1'b0;
        @(negedge clk);
        b_undo = 1'b1;
        #1;
        check("ready_during_undo", int'(cur_ready), 0);
        @(posedge clk);
        #1;
        b_undo = 1'b0;
        if (m_lv && m_cnt[0] > 0) begin
            m_board[0][m_lr][m_lc] = 2'b00;
            m_cnt[0]--;
            m_turn[0] = m_lp;
            m_win[0]  = 2'b00;
            m_draw[0] = 1'b0;
            m_lv      = 1'b0;
        end
        chk_en = 1'b1;
    endtask
`endif

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete, checks %0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        int lat, err, seen;
        checks = 0; errors = 0; chk_en = 1'b0;
        reset = 1'b0; new_game = 1'b0; b_valid = 1'b0; b_player = 2'b00;
        b_row = 3'd0; b_col = 3'd0; b_undo = 1'b0; sel = 1'b0; rd_ptr = 6'd0;
        model_clear();

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("ready_in_reset", int'(cur_ready), 0);
        check("ack_in_reset", int'(cur_ack), 0);
        check("err_in_reset", int'(cur_err), 0);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("ready_after_reset", int'(cur_ready), 1);
        check("turn_after_reset", int'(cur_turn), 1);
        chk_en = 1'b1;
        repeat (70) @(negedge clk);

        // First move latency and turn hand-off
        play(0, 2'b01, 0, 0, lat, err);
        check("first_latency", lat, 22);
        check("first_err", err, 0);
        check("first_turn", int'(cur_turn), 2);

        // Row win by early exit, then game over
        play(0, 2'b10, 1, 0, lat, err);
        play(0, 2'b01, 0, 1, lat, err);
        play(0, 2'b10, 1, 1, lat, err);
        play(0, 2'b01, 0, 2, lat, err);
        check("row_win_latency", lat, 5);
        check("row_win", int'(cur_win), 1);
        play(0, 2'b10, 2, 2, lat, err);
        check("game_over_err", err, 1);

        // Occupied cell and the other error codes
        do_new_game();
        play(0, 2'b01, 1, 1, lat, err);
        play(0, 2'b10, 1, 1, lat, err);
        check("occupied_err", err, 5);
        check("occupied_latency", lat, 2);
        check("occupied_turn", int'(cur_turn), 2);
        play(0, 2'b00, 0, 0, lat, err);
        check("bad_player_err", err, 2);
        play(0, 2'b01, 3, 0, lat, err);
        check("range_err", err, 3);
        play(0, 2'b01, 2, 2, lat, err);
        check("wrong_turn_err", err, 4);
        repeat (70) @(negedge clk);

        // Full board with no line
        do_new_game();
        play(0, 2'b01, 0, 0, lat, err);
        play(0, 2'b10, 0, 1, lat, err);
        play(0, 2'b01, 0, 2, lat, err);
        play(0, 2'b10, 1, 1, lat, err);
        play(0, 2'b01, 1, 0, lat, err);
        play(0, 2'b10, 1, 2, lat, err);
        play(0, 2'b01, 2, 1, lat, err);
        play(0, 2'b10, 2, 0, lat, err);
        play(0, 2'b01, 2, 2, lat, err);
        check("draw_err", err, 0);
        check("draw_flag", int'(cur_draw), 1);
        check("draw_no_win", int'(cur_win), 0);
        play(0, 2'b10, 0, 0, lat, err);
        check("after_draw_err", err, 1);

`ifdef TTT_UNDO_EN
        // Single-level undo
        do_new_game();
        play(0, 2'b01, 0, 0, lat, err);
        play(0, 2'b10, 2, 2, lat, err);
        do_undo();
        check("undo_turn", int'(cur_turn), 2);
        repeat (70) @(negedge clk);
        do_undo();
        check("undo_twice_turn", int'(cur_turn), 2);
        repeat (70) @(negedge clk);
        play(0, 2'b10, 2, 2, lat, err);
        check("replay_after_undo", err, 0);
`endif

        // 5x5, K=4 anti-diagonal
        do_new_game();
        play(1, 2'b01, 0, 3, lat, err);
        play(1, 2'b10, 0, 0, lat, err);
        play(1, 2'b01, 1, 2, lat, err);
        play(1, 2'b10, 0, 1, lat, err);
        play(1, 2'b01, 2, 1, lat, err);
        play(1, 2'b10, 1, 0, lat, err);
        play(1, 2'b10, 5, 0, lat, err);
        check("n5_range_err", err, 3);
        play(1, 2'b01, 3, 0, lat, err);
        check("anti_win_latency", lat, 27);
        check("anti_win", int'(cur_win), 1);
        repeat (70) @(negedge clk);

        // new_game together with move_valid: no transfer
        sel = 1'b0;
        @(negedge clk);
        new_game = 1'b1; b_valid = 1'b1; b_player = 2'b01; b_row = 3'd0; b_col = 3'd0;
        #1;
        check("ready_during_new_game", int'(cur_ready), 0);
        @(posedge clk);
        #1;
        new_game = 1'b0; b_valid = 1'b0;
        model_clear();
        seen = 0;
        repeat (30) begin
            @(posedge clk);
            #1;
            if (cur_ack) seen = 1;
        end
        check("no_ack_after_new_game_valid", seen, 0);

        // new_game mid-scan aborts without ack
        chk_en = 1'b0;
        sel = 1'b0;
        send(2'b01, 0, 0);
        repeat (4) @(posedge clk);
        #1;
        new_game = 1'b1;
        @(posedge clk);
        #1;
        new_game = 1'b0;
        model_clear();
        check("abort_turn", int'(cur_turn), 1);
        chk_en = 1'b1;
        seen = 0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (cur_ack) seen = 1;
        end
        check("abort_no_ack", seen, 0);
        repeat (70) @(negedge clk);

        chk_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/ttt_board_engine.md
Name: ttt_board_engine

Overview:
- Parametrised successor to the fixed 3x3 board, turn controller and win checker.
- Holds an N x N board and accepts moves over a valid/ready handshake. It validates each move, writes the cell, and runs a sequential K-in-a-row scan centred on the placed cell.
- Sits between the input pin controller and the output scan controller. Provides a combinational cell read port for display cycling.

Parameters:
- N, 3, board side length; legal 3..8.
- K, 3, run length needed to win; legal 3..N.
- Derived localparams:
  - AW = $clog2(N), coordinate width, minimum 1.
  - MW = $clog2(N*N+1), move-count width.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- new_game  in  1  synchronous clear of board, turn, counters and results.
- move_valid  in  1  move request.
- move_ready  out  1  engine can accept a move.
- move_player  in  2  01=X, 10=O; 00 and 11 are illegal.
- move_row  in  AW  target row.
- move_col  in  AW  target column.
- move_ack  out  1  one-cycle pulse: move fully processed.
- move_err  out  3  result code, valid with move_ack.
- rd_row  in  AW  read-port row.
- rd_col  in  AW  read-port column.
- rd_cell  out  2  combinational contents of (rd_row, rd_col); 00 if out of range.
- turn  out  2  player expected next: 01=X, 10=O.
- win  out  2  00 none, 01 X won, 10 O won.
- draw  out  1  board full, no winner.

Behaviour:
- Cell encoding: 00 empty, 01 X, 10 O.
- Reset (reset=0, async):
  - All cells 00, turn=01, win=00, draw=0, move_ack=0, move_err=0, move_ready=0, move count 0, FSM in IDLE.
  - move_ready rises the first cycle after reset deasserts.
- FSM states:
  - IDLE: move_ready=1 unless new_game=1. A transfer occurs when move_valid & move_ready.
  - CHECK: one cycle. Evaluates errors against the captured move.
    - Error present: go to DONE with the code, no write.
    - No error: write the cell, increment the move count, go to SCAN.
  - SCAN: 4 directions in fixed order (row, column, diagonal, anti-diagonal).
    - Each direction steps offset s = -(K-1)..+(K-1), one cell per cycle: 2K-1 cycles per direction, 4(2K-1) cycles total.
    - Run counter resets at each direction start. It increments on a cell equal to the mover's mark and clears on mismatch or off-board.
    - When run == K: set win = mover's mark and go to DONE immediately (early exit).
  - DONE: one cycle.
    - Pulse move_ack and drive move_err.
    - If no error and no win: toggle turn. If the move count == N*N, set draw=1.
    - Return to IDLE.
- Latency, handshake to ack:
  - Error: 2 cycles.
  - No win: 4(2K-1)+2 cycles.
  - Win: ends earlier.
- Error codes, priority high to low:
  - 1: game over (win!=00 or draw=1).
  - 2: illegal player encoding.
  - 3: row or column >= N.
  - 4: wrong turn (move_player != turn).
  - 5: cell occupied.
  - 0: accepted.
- Captured move fields are registered at the handshake. Later changes on the inputs are ignored until the next transfer.
- new_game:
  - Takes priority over everything, in any state: clears the board, turn=01, win, draw and count; returns to IDLE.
  - Mid-scan it aborts with no move_ack.
  - With move_valid in the same cycle: move_ready=0, so no transfer occurs.
- move_err holds its value until the next move_ack. move_ack is high for exactly one cycle per accepted handshake.
- win and draw are sticky until new_game or reset. Once set, all later moves get error 1.

Optional Feature:
- Macro TTT_UNDO_EN.
- With the macro defined:
  - Input port undo (1 bit) is added, sampled only in IDLE.
  - When undo=1 and count>0: clear the last successfully written cell, decrement count, restore turn to that cell's player, clear win and draw. Takes one cycle with move_ready=0.
  - Only one level of undo: a second undo with no intervening accepted move is ignored.
  - undo and move_valid in the same cycle: undo wins.
- Without the macro: no undo port and no last-move history registers.

Test Plan:
- Reset release, N=3 K=3:
  - move_ready=1 next cycle; turn=01, win=00, all rd_cell=00.
  - X(0,0) -> move_ack after 22 cycles, err=0, turn=10.
- X at (0,0), (0,1), (0,2) with O at (1,0), (1,1) in between -> third X move gives win=01 via early exit in the row direction; next O move returns err=1.
- X(1,1) accepted, then O(1,1) -> err=5 with 2-cycle latency; turn stays 10; cell (1,1) stays 01.
- N=5 K=4:
  - Anti-diagonal X at (0,3), (1,2), (2,1), (3,0) with O filler moves -> win=01 on the 4th X.
  - O move at row 5 -> err=3.
- Fill a 3x3 board with no line -> 9th move acks err=0, draw=1, win=00.
- Assert new_game mid-SCAN -> no move_ack, board cleared, turn=01 next cycle.
- With TTT_UNDO_EN: undo after O(2,2) -> cell 00, turn=10, count decremented; second undo ignored.
